exu_ctl: RTL and testbench
==========================

// Module: exu_ctl
// PURPOSE
//   Sequencing controller for the execute stage. Accepts one decoded op at a time from the IDU
//   over a valid/ready handshake and loads the EXU operand register. It times single-cycle ALU ops
//   and multi-cycle ops (MUL/DIV), then presents the result to the LSU over valid/ready.
//   It converts the EXU jump outputs into a one-cycle redirect/flush pulse to IFU/IDU, and halts
//   the core on JMP_E.
// PARAMETERS
//   MUL_LAT     4            cycles a multi-cycle op occupies the EXU (legal 1..16; 1 = single-cycle)
//   ADDR_WIDTH  `ADDR_WIDTH  redirect PC width (from cfg.sv)
//   ARGS_WIDTH  `ARGS_WIDTH  jump-type field width (from cfg.sv)
// PORTS
//   i_sys_clk          in   1           clock
//   i_sys_rst          in   1           reset; asynchronous, active-high
//   i_idu_valid        in   1           IDU offers a decoded op
//   o_exu_ready        out  1           EXU can accept an op this cycle
//   i_idu_multi        in   1           offered op is multi-cycle (sampled at accept)
//   i_idu_jmp_type     in   ARGS_WIDTH  JMP_* code of offered op (sampled at accept)
//   o_exu_ld           out  1           load EXU operand/control register (= accept handshake)
//   o_exu_step         out  1           advance multi-cycle unit one iteration
//   i_exu_jmp_en       in   1           EXU datapath jump decision (valid in DONE)
//   i_exu_jmp_pc       in   ADDR_WIDTH  EXU datapath jump target
//   o_exu_valid        out  1           result valid to LSU
//   i_lsu_ready        in   1           LSU accepts result
//   o_exu_redirect     out  1           one-cycle redirect pulse to IFU
//   o_exu_redirect_pc  out  ADDR_WIDTH  redirect target (registered)
//   o_exu_flush        out  1           flush IFU/IDU; same cycle as o_exu_redirect
//   o_exu_halt         out  1           JMP_E retired; core halted
//   o_exu_busy         out  1           state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, counter=0, r_jmp_type=0, redirect_pc=0. While i_sys_rst=1, all outputs are 0,
//     including o_exu_ready. Reset mid-op abandons the op; no valid or redirect is emitted.
//   FSM states: IDLE, EXEC, DONE, HALT.
//   IDLE: o_exu_ready=1. Accept = i_idu_valid & o_exu_ready.
//     On accept: o_exu_ld=1 and capture i_idu_multi and i_idu_jmp_type.
//     If multi and MUL_LAT>1: go EXEC with cnt=MUL_LAT-1. Otherwise go DONE.
//   EXEC: o_exu_step=1 each cycle and cnt decrements. When cnt==1, go DONE.
//     A multi op therefore spends MUL_LAT cycles from accept to first o_exu_valid; a single op
//     spends 1 cycle. i_idu_valid is ignored in EXEC.
//   DONE: o_exu_valid=1 and is held until i_lsu_ready. The result must stay stable while stalled.
//     First DONE cycle only:
//       - If i_exu_jmp_en and type!=JMP_E: o_exu_redirect=o_exu_flush=1 and the PC is latched.
//         The pulse is never repeated during an LSU stall.
//       - If type==JMP_E: o_exu_flush=1 and no redirect.
//     o_exu_ready in DONE = i_lsu_ready & ~jump_taken & (type!=JMP_E), giving back-to-back accept.
//       On that accept, the next state follows the IDLE rules.
//     If i_lsu_ready arrives without an accept, go IDLE.
//     If i_lsu_ready arrives and type==JMP_E, go HALT.
//     A jump-taken op returns to IDLE after its handshake; the upstream op is flushed, not accepted.
//   HALT: o_exu_halt=1, all other outputs 0. Only reset exits HALT.
//   Simultaneous redirect pulse and LSU handshake in the same cycle is legal.
//   o_exu_redirect_pc is registered: it is valid in the pulse cycle and held until the next redirect.
//   Counter width is $clog2(MUL_LAT+1). MUL_LAT=1 makes multi ops behave as single-cycle.
//   Throughput: 1 op/cycle for single-cycle ops with LSU always ready.
// STRUCTURE
//   Shared package exu_pkg: exu_ctl_state_e {IDLE,EXEC,DONE,HALT}; the JMP_* codes stay in cfg.sv.
//   One sub-module: exu_lat_cnt, a loadable down-counter with load/dec/zero flags.
//   The FSM and the redirect register live in exu_ctl.
//   exu_ctl sits between the idu and exu instances in the core top.
// TESTING
//   1. Single op, LSU ready: valid@t0 -> ld@t0, o_exu_valid@t1 for 1 cycle, back in IDLE@t2.
//   2. Multi op, MUL_LAT=4: accept@t0 -> step high t1..t3, o_exu_valid@t4, busy t1..t4.
//   3. LSU stall 3 cycles, jmp_en=1, pc=0x8000_0010 -> exactly one redirect/flush pulse on the
//      first DONE cycle with pc 0x8000_0010; valid held 4 cycles; no accept in DONE.
//   4. Back-to-back 5 single ops, LSU always ready -> 5 results on 5 consecutive cycles;
//      ready never drops.
//   5. JMP_E op -> flush pulse, no redirect, halt=1 after handshake; further i_idu_valid ignored.
//      Reset then gives IDLE with ready=1.
//   6. Assert reset in EXEC cycle 2 -> all outputs 0 asynchronously; no valid or redirect after release.

Source files
------------

// File: rtl/exu_pkg.sv
// Shared types and configuration for the execute-stage controller.
// Widths and the halt jump code used by exu_ctl and its bench.
package exu_pkg;

  localparam int EXU_ADDR_W = 32;
  localparam int EXU_ARGS_W = 3;
  localparam logic [EXU_ARGS_W-1:0] EXU_JMP_E = '1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE,
    HALT
  } exu_ctl_state_e;

endpackage

// File: rtl/exu_lat_cnt.sv
// Loadable down-counter timing multi-cycle EXU ops.
// Flags report when the count sits at zero or at one.
module exu_lat_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt;

    // Load wins over decrement; the count never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == W'(1));

endmodule

// File: rtl/exu_ctl.sv
// Execute-stage sequencing controller: accept, time, deliver,
// redirect/flush on jumps and halt the core on JMP_E.
module exu_ctl
    import exu_pkg::*;
#(
    parameter int MUL_LAT    = 4,
    parameter int ADDR_WIDTH = EXU_ADDR_W,
    parameter int ARGS_WIDTH = EXU_ARGS_W
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_idu_valid,
    output logic                  o_exu_ready,
    input  logic                  i_idu_multi,
    input  logic [ARGS_WIDTH-1:0] i_idu_jmp_type,
    output logic                  o_exu_ld,
    output logic                  o_exu_step,
    input  logic                  i_exu_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
    output logic                  o_exu_valid,
    input  logic                  i_lsu_ready,
    output logic                  o_exu_redirect,
    output logic [ADDR_WIDTH-1:0] o_exu_redirect_pc,
    output logic                  o_exu_flush,
    output logic                  o_exu_halt,
    output logic                  o_exu_busy
);

    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] LOAD_V = CW'(MUL_LAT - 1);
    localparam logic MULTI_EN = (MUL_LAT > 1);
    localparam logic [ARGS_WIDTH-1:0] JMP_E_C = ARGS_WIDTH'(EXU_JMP_E);

    exu_ctl_state_e state;
    logic [ARGS_WIDTH-1:0] r_jmp_type;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic r_first;
    logic r_jt;

    logic in_idle, in_exec, in_done, in_halt;
    logic is_e, jt_now, redirect, accept, go_exec;
    logic cnt_zero, cnt_one;

    assign in_idle = ~i_sys_rst & (state == IDLE);
    assign in_exec = ~i_sys_rst & (state == EXEC);
    assign in_done = ~i_sys_rst & (state == DONE);
    assign in_halt = ~i_sys_rst & (state == HALT);

    assign is_e = (r_jmp_type == JMP_E_C);

    // After the first DONE cycle the jump decision comes from r_jt,
    // so an LSU stall cannot re-fire or change the redirect.
    assign jt_now = r_first ? (i_exu_jmp_en & ~is_e) : r_jt;

    assign o_exu_ready = in_idle
                       | (in_done & i_lsu_ready & ~jt_now & ~is_e);
    assign accept  = i_idu_valid & o_exu_ready;
    assign go_exec = accept & i_idu_multi & MULTI_EN;

    assign redirect = in_done & r_first & i_exu_jmp_en & ~is_e;

    exu_lat_cnt #(
        .W(CW)
    ) u_cnt (
        .clk     (i_sys_clk),
        .rst     (i_sys_rst),
        .load    (go_exec),
        .dec     (in_exec),
        .load_val(LOAD_V),
        .zero    (cnt_zero),
        .one     (cnt_one)
    );

    // Main sequencer plus capture of op type, jump flag and target.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state      <= IDLE;
            r_jmp_type <= '0;
            r_pc       <= '0;
            r_first    <= 1'b0;
            r_jt       <= 1'b0;
        end else begin
            r_first <= 1'b0;
            if (r_first) begin
                r_jt <= jt_now;
            end
            if (redirect) begin
                r_pc <= i_exu_jmp_pc;
            end
            if (accept) begin
                r_jmp_type <= i_idu_jmp_type;
                r_jt       <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= go_exec ? EXEC : DONE;
                        r_first <= ~go_exec;
                    end
                end
                EXEC: begin
                    if (cnt_one | cnt_zero) begin
                        state   <= DONE;
                        r_first <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_lsu_ready) begin
                        if (is_e) begin
                            state <= HALT;
                        end else if (accept) begin
                            state   <= go_exec ? EXEC : DONE;
                            r_first <= ~go_exec;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_exu_ld    = accept;
    assign o_exu_step  = in_exec;
    assign o_exu_valid = in_done;
    assign o_exu_redirect = redirect;
    assign o_exu_flush = in_done & r_first
                       & ((i_exu_jmp_en & ~is_e) | is_e);
    assign o_exu_halt  = in_halt;
    assign o_exu_busy  = in_exec | in_done;

    // Target is live in the pulse cycle, then held from r_pc.
    assign o_exu_redirect_pc = in_halt  ? '0
                             : redirect ? i_exu_jmp_pc
                             : r_pc;

endmodule

// File: tb/tb_exu_ctl.sv
// Randomized scoreboard bench for exu_ctl with a timing-based model.
// Covers single/multi ops, stalls, jumps, halt and async reset.
module tb_exu_ctl;
    import exu_pkg::*;

    localparam int LAT = 4;
    localparam int AW  = 32;
    localparam int TW  = 3;
    localparam logic [TW-1:0] JE = TW'(EXU_JMP_E);

    logic clk = 1'b0;
    logic rst;
    logic i_idu_valid, i_idu_multi, i_exu_jmp_en, i_lsu_ready;
    logic [TW-1:0] i_idu_jmp_type;
    logic [AW-1:0] i_exu_jmp_pc;
    logic o_exu_ready, o_exu_ld, o_exu_step, o_exu_valid;
    logic o_exu_redirect, o_exu_flush, o_exu_halt, o_exu_busy;
    logic [AW-1:0] o_exu_redirect_pc;

    exu_ctl #(
        .MUL_LAT(LAT), .ADDR_WIDTH(AW), .ARGS_WIDTH(TW)
    ) dut (
        .i_sys_clk        (clk),
        .i_sys_rst        (rst),
        .i_idu_valid      (i_idu_valid),
        .o_exu_ready      (o_exu_ready),
        .i_idu_multi      (i_idu_multi),
        .i_idu_jmp_type   (i_idu_jmp_type),
        .o_exu_ld         (o_exu_ld),
        .o_exu_step       (o_exu_step),
        .i_exu_jmp_en     (i_exu_jmp_en),
        .i_exu_jmp_pc     (i_exu_jmp_pc),
        .o_exu_valid      (o_exu_valid),
        .i_lsu_ready      (i_lsu_ready),
        .o_exu_redirect   (o_exu_redirect),
        .o_exu_redirect_pc(o_exu_redirect_pc),
        .o_exu_flush      (o_exu_flush),
        .o_exu_halt       (o_exu_halt),
        .o_exu_busy       (o_exu_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int            due;
        bit            redir;
        bit            flush;
        logic [AW-1:0] pc;
    } exp_t;
    exp_t sbq[$];

    // offered op (stimulus) and op currently in the EXU
    logic          off_v, off_multi, off_jen;
    logic [TW-1:0] off_type;
    logic [AW-1:0] off_pc;
    logic          cur_jen;
    logic [AW-1:0] cur_pc;
    bit took, flushed;

    // reference model: timing derived from accept cycle and latency
    bit            m_busy, m_halt, prev_hold;
    int            m_tacc, m_lat;
    logic [TW-1:0] m_type;
    logic          m_jen;
    logic [AW-1:0] m_pc, m_lastpc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {o_exu_ready, o_exu_ld, o_exu_step, o_exu_valid,
                o_exu_redirect, o_exu_flush, o_exu_halt, o_exu_busy};
    endfunction

    // Monitor: per-cycle model checks plus scoreboard pops on results.
    always @(negedge clk) begin
        logic e_ready, e_step, e_valid, e_busy, e_halt, e_red, e_flush;
        logic e_ld, first, jt, ise;
        logic [AW-1:0] e_pc;
        int k;
        exp_t e;
        cyc++;
        if (rst) begin
            chk("rst_outs", outs(), 0);
            chk("rst_pc", o_exu_redirect_pc, 0);
            m_busy = 0; m_halt = 0; m_lastpc = '0;
            prev_hold = 0;
            sbq.delete();
        end else begin
            e_ready = 0; e_step = 0; e_valid = 0; e_busy = 0;
            e_halt = 0; e_red = 0; e_flush = 0;
            ise = (m_type == JE);
            if (m_halt) begin
                e_halt = 1;
            end else if (!m_busy) begin
                e_ready = 1;
            end else begin
                k = cyc - m_tacc;
                e_busy = 1;
                if (k < m_lat) begin
                    e_step = 1;
                end else begin
                    e_valid = 1;
                    first = (k == m_lat);
                    jt = m_jen && !ise;
                    e_red = first && jt;
                    e_flush = first && (jt || ise);
                    e_ready = i_lsu_ready && !jt && !ise;
                end
            end
            e_ld = i_idu_valid && e_ready;
            e_pc = m_halt ? '0 : (e_red ? m_pc : m_lastpc);
            chk("ready", o_exu_ready, e_ready);
            chk("ld", o_exu_ld, e_ld);
            chk("step", o_exu_step, e_step);
            chk("valid", o_exu_valid, e_valid);
            chk("busy", o_exu_busy, e_busy);
            chk("halt", o_exu_halt, e_halt);
            chk("redirect_pc", o_exu_redirect_pc, e_pc);
            if (o_exu_valid && !prev_hold) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("res_cycle", cyc, e.due);
                    chk("res_redirect", o_exu_redirect, e.redir);
                    chk("res_flush", o_exu_flush, e.flush);
                    if (e.redir)
                        chk("res_pc", o_exu_redirect_pc, e.pc);
                end
            end else begin
                chk("no_pulse", {o_exu_redirect, o_exu_flush}, 0);
            end
            prev_hold = o_exu_valid && !i_lsu_ready;
            if (e_red) m_lastpc = m_pc;
            if (e_flush) flushed = 1;
            if (e_valid && i_lsu_ready) begin
                if (ise) m_halt = 1;
                m_busy = 0;
            end
            if (e_ld) begin
                m_busy = 1;
                m_tacc = cyc;
                m_lat  = off_multi ? LAT : 1;
                m_type = off_type;
                m_jen  = off_jen;
                m_pc   = off_pc;
                cur_jen = off_jen;
                cur_pc  = off_pc;
                took = 1;
                e.due   = cyc + m_lat;
                e.redir = off_jen && (off_type != JE);
                e.flush = e.redir || (off_type == JE);
                e.pc    = off_pc;
                sbq.push_back(e);
            end
        end
    end

    task automatic drive();
        i_idu_valid    = off_v;
        i_idu_multi    = off_multi;
        i_idu_jmp_type = off_type;
        i_exu_jmp_en   = cur_jen;
        i_exu_jmp_pc   = cur_pc;
    endtask

    task automatic new_offer(input bit b2b);
        off_v     = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
        off_multi = b2b ? 1'b0 : ($urandom_range(0, 3) == 0);
        if (!b2b && $urandom_range(0, 39) == 0)
            off_type = JE;
        else
            off_type = TW'($urandom_range(0, int'(JE) - 1));
        off_jen = b2b ? 1'b0 : ($urandom_range(0, 3) == 0);
        off_pc  = $urandom;
    endtask

    initial begin
        bit in_rst, b2b;
        int hcnt;
        rst = 1;
        off_v = 0; off_multi = 0; off_jen = 0;
        off_type = '0; off_pc = '0;
        cur_jen = 0; cur_pc = '0;
        took = 0; flushed = 0;
        m_busy = 0; m_halt = 0; prev_hold = 0;
        m_tacc = 0; m_lat = 1; m_type = '0; m_jen = 0;
        m_pc = '0; m_lastpc = '0;
        i_lsu_ready = 0;
        in_rst = 0; hcnt = 0;
        drive();
        repeat (3) @(posedge clk);
        #1 rst = 0;

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            b2b = (n % 500) >= 440;
            if (in_rst) begin
                rst = 0; in_rst = 0; hcnt = 0;
            end else if (m_halt) begin
                hcnt++;
                off_v = 1;
                if (hcnt == 5) begin
                    rst = 1; in_rst = 1;
                end
            end else if (took || flushed || !off_v) begin
                new_offer(b2b);
            end
            took = 0; flushed = 0;
            i_lsu_ready = b2b ? 1'b1 : ($urandom_range(0, 9) < 7);
            drive();
        end

        // drain to idle
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (m_halt && !rst) rst = 1;
            else rst = 0;
            off_v = 0; i_lsu_ready = 1;
            drive();
        end

        // reset while a multi op is in its second EXEC cycle
        @(posedge clk);
        #1;
        off_v = 1; off_multi = 1; off_type = '0;
        off_jen = 1; off_pc = 32'h8000_0010;
        drive();
        @(posedge clk);
        #1 off_v = 0;
        drive();
        @(posedge clk);
        #2 rst = 1;
        #1 chk("async_rst_outs", outs(), 0);
        @(posedge clk);
        #1 rst = 0;
        repeat (12) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
